// File: rtl/wallace_mac_sequencer.sv
// rtl/wallace_mac_sequencer.sv - streams operand pairs into a registered 8x8 multiplier and accumulates a dot product
module wallace_mac_sequencer #(
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [MUL_LAT-1:0] tag;
    logic               handshake;
    logic               add_en;
    logic               job_start;
    logic [ACC_W:0]     sum_ext;

    assign handshake = in_valid & in_ready;
    assign add_en    = tag[MUL_LAT-1];
    assign job_start = (state == IDLE) & start;
    assign busy      = (state != IDLE);

    // Operands reach the multiplier only while a pair can be accepted, so it sees zeros otherwise
    assign mul_a = in_ready ? a_in : 8'd0;
    assign mul_b = in_ready ? b_in : 8'd0;

    // Extra top bit captures the carry out of the accumulator width
    assign sum_ext = {1'b0, acc_out} + {{(ACC_W - 15){1'b0}}, mul_p};

    // Job control: issue counting, drain wait and result handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        if (len != '0) begin
                            state    <= ISSUE;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Empty tag pipe means the final product has already been added
                    if (tag == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe marks which multiplier output cycles carry a real product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag <= '0;
        end else begin
            tag[0] <= handshake;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    // Accumulator with sticky carry-out flag, cleared when a job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (job_start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (add_en) begin
            acc_out <= sum_ext[ACC_W-1:0];
            if (sum_ext[ACC_W]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// tb/tb_wallace_mac_sequencer.sv - self-checking bench for wallace_mac_sequencer
module tb_wallace_mac_sequencer;

    localparam int ACC_W   = 16;
    localparam int LEN_W   = 8;
    localparam int MUL_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a_in;
    logic [7:0]       b_in;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [15:0]      mul_p;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         vpat[$];
    int         gap_pct;

    wallace_mac_sequencer #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_in(a_in),
        .b_in(b_in),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_p(mul_p),
        .acc_out(acc_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Registered multiplier stand-in: input register then output register, no reset
    logic [7:0] ma_q;
    logic [7:0] mb_q;
    always @(posedge clk) begin
        ma_q  <= mul_a;
        mb_q  <= mul_b;
        mul_p <= 16'(ma_q) * 16'(mb_q);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one job from the queued pairs; the model is the plain arithmetic dot product
    task automatic run_job(input string nm, input int n, input int hold);
        int total;
        int partial;
        int idx;
        int pi;
        int budget;
        int wait_n;
        bit v;
        total   = 0;
        partial = 0;
        for (int i = 0; i < n; i++) begin
            partial = total;
            total  += int'(qa[i]) * int'(qb[i]);
        end
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        check({nm, ".busy_start"}, 32'(busy), 32'd1);
        idx    = 0;
        pi     = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            if (vpat.size() > 0) begin
                v = (pi < vpat.size()) ? vpat[pi] : 1'b1;
                pi++;
            end else begin
                v = ($urandom_range(99) >= gap_pct);
            end
            in_valid = v;
            a_in     = v ? qa[idx] : 8'($urandom);
            b_in     = v ? qb[idx] : 8'($urandom);
            #1;
            check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
            check({nm, ".mul_a"}, 32'(mul_a), 32'(a_in));
            check({nm, ".mul_b"}, 32'(mul_b), 32'(b_in));
            @(negedge clk);
            if (v) idx++;
            budget++;
        end
        check({nm, ".issue_done"}, 32'(idx), 32'(n));
        in_valid = 1'b0;
        a_in     = 8'hA5;
        b_in     = 8'h5A;
        #1;
        check({nm, ".in_ready_off"}, 32'(in_ready), 32'd0);
        check({nm, ".mul_a_off"}, 32'(mul_a), 32'd0);
        check({nm, ".mul_b_off"}, 32'(mul_b), 32'd0);
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            if (n > 0 && wait_n == MUL_LAT - 1)
                check({nm, ".acc_before_last"}, 32'(acc_out), 32'(partial % (1 << ACC_W)));
            if (n > 0 && wait_n == MUL_LAT)
                check({nm, ".acc_after_last"}, 32'(acc_out), 32'(total % (1 << ACC_W)));
            check({nm, ".busy_drain"}, 32'(busy), 32'd1);
            @(negedge clk);
            #1;
            wait_n++;
        end
        check({nm, ".latency"}, 32'(wait_n), (n > 0) ? 32'(MUL_LAT + 1) : 32'd0);
        check({nm, ".out_valid"}, 32'(out_valid), 32'd1);
        check({nm, ".acc"}, 32'(acc_out), 32'(total % (1 << ACC_W)));
        check({nm, ".overflow"}, 32'(overflow), 32'(total >= (1 << ACC_W)));
        check({nm, ".in_ready_done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start     = (h % 2 == 0);
            len       = 8'd3;
            out_ready = 1'b0;
            @(negedge clk);
            check({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({nm, ".hold_acc"}, 32'(acc_out), 32'(total % (1 << ACC_W)));
            check({nm, ".hold_busy"}, 32'(busy), 32'd1);
        end
        start     = 1'b1;
        len       = 8'd2;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        check({nm, ".release_valid"}, 32'(out_valid), 32'd0);
        check({nm, ".release_busy"}, 32'(busy), 32'd0);
        qa.delete();
        qb.delete();
        vpat.delete();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a_in      = 8'h3C;
        b_in      = 8'hC3;
        out_ready = 1'b0;
        gap_pct   = 0;
        #12;
        check("reset.acc", 32'(acc_out), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        check("reset.mul_a", 32'(mul_a), 32'd0);
        check("reset.mul_b", 32'(mul_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        qa = '{8'd3, 8'd255, 8'd0};
        qb = '{8'd5, 8'd255, 8'd200};
        run_job("basic", 3, 0);

        qa = '{8'd12};
        qb = '{8'd11};
        run_job("latency", 1, 0);

        qa = '{8'd255, 8'd255};
        qb = '{8'd255, 8'd255};
        run_job("overflow", 2, 1);

        qa = '{8'd1};
        qb = '{8'd1};
        run_job("after_ovf", 1, 0);

        qa   = '{8'd1, 8'd3, 8'd5, 8'd7};
        qb   = '{8'd2, 8'd4, 8'd6, 8'd8};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_job("gaps", 4, 5);

        run_job("len0", 0, 2);

        // Abort mid-issue after two accepted pairs
        @(negedge clk);
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 8'd200;
        b_in     = 8'd200;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.acc", 32'(acc_out), 32'd0);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd0);
        check("abort.mul_a", 32'(mul_a), 32'd0);
        check("abort.overflow", 32'(overflow), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        qa = '{8'd2};
        qb = '{8'd3};
        run_job("post_abort", 1, 0);

        for (int j = 0; j < 6; j++) begin
            int n;
            n       = int'($urandom_range(1, 10));
            gap_pct = int'($urandom_range(0, 60));
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom));
                qb.push_back(8'($urandom));
            end
            run_job($sformatf("rand%0d", j), n, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wallace_mac_sequencer.md
Name: wallace_mac_sequencer

Overview:
Sequencer that streams operand pairs into the registered 8x8 Wallace-tree multiplier top and accumulates the products into a dot-product result.
- Owns the multiplier's A_in/B_in inputs and consumes its S_out.
- Tracks products through the multiplier's 2-cycle register latency with a tag pipeline.
- Returns one accumulated sum per job over a valid/ready handshake.

Parameters:
ACC_W, 24, accumulator/result width in bits (must be >= 16)
LEN_W, 8, width of job length field (max pairs per job = 2^LEN_W - 1)
MUL_LAT, 2, clock edges from A_in/B_in capture to product use (multiplier input reg + output reg)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  job request pulse, sampled only in IDLE
len  input  LEN_W  number of operand pairs in job, sampled with start
busy  output  1  high in any state other than IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operand pair
a_in  input  8  operand A (unsigned)
b_in  input  8  operand B (unsigned)
mul_a  output  8  to multiplier A_in
mul_b  output  8  to multiplier B_in
mul_p  input  16  from multiplier S_out
acc_out  output  ACC_W  accumulated result, stable while out_valid
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
overflow  output  1  sticky: accumulator carried out of ACC_W this job

Behaviour:
- Reset (async): state=IDLE; acc_out=0, out_valid=0, overflow=0, busy=0, in_ready=0; issue counter=0; tag pipe cleared; mul_a=mul_b=0.
- The multiplier has no reset. Its outputs are used only when the tag says so, so stale multiplier contents after reset are ignored.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1 at an edge, clear acc_out and overflow, latch len, and load remaining=len.
  - len!=0 -> ISSUE.
  - len==0 -> DONE with acc_out=0.
- ISSUE:
  - in_ready=1 whenever remaining!=0.
  - A handshake (in_valid&in_ready at edge t) decrements remaining and sets tag[0].
  - mul_a/mul_b = a_in/b_in combinationally while in_ready, else 0.
  - When remaining reaches 0 -> DRAIN.
  - Gaps in in_valid are legal; tag[0]=0 on idle cycles.
- Tag pipe: tag[i] <= tag[i-1] each edge.
  - At an edge where tag[MUL_LAT-1]=1: acc_out <= acc_out + zero-extended mul_p.
  - If that add carries out of ACC_W, set overflow=1; acc_out wraps modulo 2^ACC_W.
  - A pair accepted at edge t is therefore added at edge t+MUL_LAT.
  - Back-to-back issue gives one add per cycle.
- DRAIN: in_ready=0. Once the tag pipe is all zero after the final add edge, go to DONE on the next edge.
- DONE:
  - out_valid=1; acc_out and overflow held.
  - On out_valid&out_ready: out_valid=0 and go to IDLE on that edge.
  - start in the same cycle is ignored; it is accepted from IDLE on a later edge.
- start asserted outside IDLE is ignored; no queueing.
- rst mid-job aborts immediately: partial sum discarded, no out_valid.
- Minimum job latency with continuous in_valid: pairs issued at edges 1..len, last add at edge len+MUL_LAT, out_valid seen after the following edge.

Test Plan:
- Basic dot product: start, len=3, pairs (3,5),(255,255),(0,200) back-to-back -> acc_out=65040 (0xFE10), overflow=0, out_valid exactly one cycle after drain, busy high throughout.
- Latency check: len=1, pair (12,11) -> product 132 added exactly MUL_LAT edges after the handshake; out_valid one edge later; mul_a/mul_b equal 12/11 only in the handshake cycle.
- Overflow: ACC_W=16, len=2, pairs (255,255) x2 -> acc_out=64514 (0xFC02), overflow=1; next job len=1 (1,1) -> acc_out=1, overflow=0.
- Backpressure/gaps: len=4, in_valid toggling 1,0,0,1,1,0,1 with pairs (1,2),(3,4),(5,6),(7,8); out_ready held low 5 cycles -> acc_out=100 stable, out_valid held; start pulses in DONE are ignored.
- len=0 job -> DONE next edge, acc_out=0, in_ready never asserted.
- Async reset mid-ISSUE after 2 of 4 pairs -> all outputs zero immediately; a new job len=1 (2,3) then yields acc_out=6 with no contamination from in-flight products.
